// File: rtl/clockdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Divisor arithmetic is unsigned throughout.
package clockdiv_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_PIXEL = 2;   // 50 MHz master -> 25 MHz pixel enable
    localparam int DIV_MIN   = 1;

    // High-phase length of a period: ceil(d/2) == (d >> 1) + d[0].
    function automatic logic [31:0] half_up(input logic [31:0] d);
        return (d >> 1) + {31'b0, d[0]};
    endfunction

endpackage

// File: rtl/clockdiv_if.sv
// Control/status bundle of the programmable clock divider.
// The master side programs the divisor; the slave side is the divider itself.
interface clockdiv_if #(
    parameter int WIDTH = clockdiv_pkg::DIV_WIDTH
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] div_active;
    logic             div_pending;
    logic             load_err;

    modport master (
        output en,
        output div_in,
        output div_load,
        input  clk_out,
        input  tick,
        input  div_active,
        input  div_pending,
        input  load_err
    );

    modport slave (
        input  en,
        input  div_in,
        input  div_load,
        output clk_out,
        output tick,
        output div_active,
        output div_pending,
        output load_err
    );
endinterface

// File: rtl/clockdiv_core.sv
// Period counter and square-wave generator for a given active divisor.
// Flags the period boundary so the owner of the divisor can swap it in.
module clockdiv_core
    import clockdiv_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int RST_DIV = DIV_PIXEL
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    output logic             boundary,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_last;
    logic [WIDTH-1:0] half;

    // div is never zero, so div-1 cannot wrap and cnt+1 stays below 2^WIDTH.
    assign cnt_last = div - WIDTH'(1);
    assign cnt_inc  = cnt + WIDTH'(1);
    assign half     = WIDTH'(half_up(32'(div)));
    assign boundary = en && (cnt == cnt_last);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            // Preset to the last count so the first enabled edge starts a period.
            cnt     <= WIDTH'(RST_DIV - 1);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            tick    <= 1'b0;
        end else if (boundary) begin
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
        end else begin
            cnt     <= cnt_inc;
            tick    <= 1'b0;
            if (cnt_inc == half) begin
                clk_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clockdiv_prog.sv
// Runtime-programmable clock divider: divided clock plus period-start strobe.
// New divisors are shadowed and only take effect at a period boundary.
module clockdiv_prog
    import clockdiv_pkg::*;
#(
    parameter int WIDTH       = DIV_WIDTH,
    parameter int DEFAULT_DIV = DIV_PIXEL
) (
    input  logic       clk,
    input  logic       clr_n,
    clockdiv_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("clockdiv_prog: WIDTH must be within 1..32");
    end

    if (DEFAULT_DIV < DIV_MIN ||
        longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_default
        $error("clockdiv_prog: DEFAULT_DIV must be within 1..2^WIDTH-1");
    end

    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] div_shadow;
    logic             div_pending;
    logic             load_err;
    logic             boundary;
    logic             clk_out;
    logic             tick;

    logic [WIDTH-1:0] div_active_nxt;
    logic [WIDTH-1:0] div_shadow_nxt;
    logic             div_pending_nxt;
    logic             load_err_nxt;
    logic             load_ok;

    assign load_ok = bus.div_load && (bus.div_in != '0);

    // A load landing on the boundary edge bypasses the shadow register.
    always_comb begin
        div_active_nxt  = div_active;
        div_shadow_nxt  = div_shadow;
        div_pending_nxt = div_pending;
        load_err_nxt    = bus.div_load && (bus.div_in == '0);

        if (boundary) begin
            if (load_ok) begin
                div_active_nxt = bus.div_in;
                div_shadow_nxt = bus.div_in;
            end else if (div_pending) begin
                div_active_nxt = div_shadow;
            end
            div_pending_nxt = 1'b0;
        end else if (load_ok) begin
            div_shadow_nxt  = bus.div_in;
            div_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            div_active  <= WIDTH'(DEFAULT_DIV);
            div_shadow  <= '0;
            div_pending <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            div_active  <= div_active_nxt;
            div_shadow  <= div_shadow_nxt;
            div_pending <= div_pending_nxt;
            load_err    <= load_err_nxt;
        end
    end

    clockdiv_core #(
        .WIDTH   (WIDTH),
        .RST_DIV (DEFAULT_DIV)
    ) u_core (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (bus.en),
        .div      (div_active),
        .boundary (boundary),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    assign bus.clk_out     = clk_out;
    assign bus.tick        = tick;
    assign bus.div_active  = div_active;
    assign bus.div_pending = div_pending;
    assign bus.load_err    = load_err;

endmodule
